// File: rtl/spi_program_loader_pkg.sv
// Shared definitions for the SPI program loader: sequencer states,
// instruction width and status-byte layout.
package spi_program_loader_pkg;

  localparam int unsigned INSTR_WIDTH    = 16;
  localparam int unsigned STATUS_RUN_BIT = 7;
  localparam int unsigned STATUS_LEN_MSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [7:0] status_byte(input logic was_run, input logic [5:0] len);
    logic [7:0] s;
    s = '0;
    s[STATUS_RUN_BIT] = was_run;
    s[STATUS_LEN_MSB:0] = len;
    return s;
  endfunction

endpackage

// File: rtl/spi_program_loader_if.sv
// SPI bus between the host (master) and the program loader (slave).
interface spi_program_loader_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, cs_n, mosi, input miso);
  modport slave  (input sclk, cs_n, mosi, output miso);
endinterface

// File: rtl/spi_program_loader_rx.sv
// SPI mode-0 slave front end: input synchronisers, edge detection,
// 16-bit word shift-in and status-byte shift-out.
module spi_slave_rx
  import spi_program_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk,
  input  logic                   cs_n,
  input  logic                   mosi,
  input  logic [7:0]             status_in,
  output logic                   miso,
  output logic                   cs_fall,
  output logic                   cs_rise,
  output logic                   word_valid,
  output logic [INSTR_WIDTH-1:0] word
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic [$clog2(INSTR_WIDTH)-1:0] bit_cnt;
  logic [7:0] tx_q;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign miso      = tx_q[7];

  // cs_n syncs reset to the deasserted level so release never fakes a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (cs_fall || cs_rise) begin
        bit_cnt <= '0;
      end else if (!cs_s && sclk_rise) begin
        word       <= {word[INSTR_WIDTH-2:0], mosi_s};
        bit_cnt    <= bit_cnt + 1'b1;
        word_valid <= &bit_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (cs_fall) begin
      tx_q <= status_in;
    end else if (!cs_s && sclk_fall) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_program_loader.sv
// SPI-loaded instruction store plus looping sequencer feeding the
// execution stage one pc/opcode/operand/valid tuple per enabled cycle.
module spi_program_loader
  import spi_program_loader_pkg::*;
#(
  parameter int unsigned ROM_ADDRESS_WIDTH = 5,
  parameter int unsigned INPUT_DATA_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  spi_program_loader_if.slave           spi,
  input  logic                          run_en,
  output logic [2*INPUT_DATA_WIDTH-1:0] pc,
  output logic [2*INPUT_DATA_WIDTH-1:0] opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0] operand,
  output logic                          valid,
  output logic [ROM_ADDRESS_WIDTH:0]    prog_len,
  output logic                          loading
);

  localparam int unsigned DEPTH = 1 << ROM_ADDRESS_WIDTH;
  localparam int unsigned BW    = 2 * INPUT_DATA_WIDTH;
  localparam logic [ROM_ADDRESS_WIDTH:0] FULL = (ROM_ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ROM_ADDRESS_WIDTH:0] ONE  = {{ROM_ADDRESS_WIDTH{1'b0}}, 1'b1};

  typedef logic [ROM_ADDRESS_WIDTH-1:0] addr_t;

  state_t state, state_next;
  logic cs_fall, cs_rise, word_valid;
  logic [INSTR_WIDTH-1:0] word;
  logic [7:0] status;
  addr_t wptr, pc_q, rd_addr;
  logic [ROM_ADDRESS_WIDTH:0] count;
  logic last;
  logic [INSTR_WIDTH-1:0] store [DEPTH];

  assign status  = status_byte(state == ST_RUN, prog_len[5:0]);
  assign loading = (state == ST_LOAD);
  assign pc      = {{(BW - ROM_ADDRESS_WIDTH){1'b0}}, pc_q};
  assign last    = ({1'b0, pc_q} == (prog_len - ONE));

  // After a presented tuple advance; after a hold (or from start) re-read pc
  assign rd_addr = valid ? (last ? '0 : pc_q + addr_t'(1)) : pc_q;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst_n      (reset),
    .sclk       (spi.sclk),
    .cs_n       (spi.cs_n),
    .mosi       (spi.mosi),
    .status_in  (status),
    .miso       (spi.miso),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_fall) begin
      state_next = ST_LOAD;
    end else if (state == ST_LOAD && cs_rise) begin
      state_next = (count != '0) ? ST_RUN : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      opcode   <= '0;
      operand  <= '0;
      valid    <= 1'b0;
      prog_len <= '0;
      wptr     <= '0;
      count    <= '0;
    end else if (cs_fall) begin
      valid <= 1'b0;
      pc_q  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (word_valid) begin
            wptr  <= wptr + addr_t'(1);
            count <= (count == FULL) ? FULL : count + ONE;
          end
          if (cs_rise) prog_len <= count;
        end
        ST_RUN: begin
          if (run_en) begin
            pc_q    <= rd_addr;
            opcode  <= store[rd_addr][INSTR_WIDTH-1 -: BW];
            operand <= store[rd_addr][BW-1:0];
            valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD && word_valid && !cs_fall) store[wptr] <= word;
  end

endmodule

// File: tb/tb_spi_program_loader.sv
// Self-checking bench: SPI host tasks, a program model of the store and
// the looping sequencer, and one task per scenario.
module tb_spi_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run_en = 1'b0;
  logic [7:0] pc, opcode, operand;
  logic valid, loading;
  logic [5:0] prog_len;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] model_store [32];
  int model_len = 0;

  spi_program_loader_if spi_bus();

  always #5 clk = ~clk;

  spi_program_loader #(
    .ROM_ADDRESS_WIDTH(5),
    .INPUT_DATA_WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (spi_bus),
    .run_en   (run_en),
    .pc       (pc),
    .opcode   (opcode),
    .operand  (operand),
    .valid    (valid),
    .prog_len (prog_len),
    .loading  (loading)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  // SPI mode 0: host drives mosi while sclk low, samples miso on the rise
  task automatic spi_shift(input logic [31:0] data, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bus.mosi = data[i];
      #40 spi_bus.sclk = 1'b1;
      rx = {rx[30:0], spi_bus.miso};
      #40 spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_bus.cs_n = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #100 spi_bus.cs_n = 1'b1;
  endtask

  task automatic model_program(input logic [15:0] words[$]);
    for (int i = 0; i < words.size(); i++) model_store[i % 32] = words[i];
    model_len = (words.size() > 32) ? 32 : words.size();
  endtask

  task automatic load_program(input logic [15:0] words[$], input int extra_bits);
    logic [31:0] rx;
    spi_begin();
    foreach (words[i]) spi_shift({16'h0, words[i]}, 16, rx);
    if (extra_bits > 0) spi_shift($urandom, extra_bits, rx);
    spi_end();
    model_program(words);
  endtask

  task automatic wait_first_valid(input string name);
    int t;
    t = 0;
    while (!valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first_valid: got valid=%b after %0d cycles, expected 1", name, valid, t);
    end
  endtask

  task automatic test_reset();
    #23;
    n_checks++;
    if ({pc, opcode, operand, valid, prog_len, loading, spi_bus.miso} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%h op=%h opr=%h v=%b len=%0d ld=%b miso=%b, expected all 0",
               pc, opcode, operand, valid, prog_len, loading, spi_bus.miso);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_load();
    logic [15:0] q[$];
    int exp_pc;
    q = '{16'h01A5, 16'h0233, 16'h0400};
    run_en = 1'b1;
    load_program(q, 0);
    @(negedge clk);
    wait_first_valid("basic");
    n_checks++;
    if (prog_len !== 6'(model_len)) begin
      n_fail++;
      $display("FAIL basic_prog_len: got %0d expected %0d", prog_len, model_len);
    end
    exp_pc = 0;
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (valid !== 1'b1 || pc !== 8'(exp_pc) || opcode !== model_store[exp_pc][15:8] ||
          operand !== model_store[exp_pc][7:0]) begin
        n_fail++;
        $display("FAIL basic_tuple[%0d]: got v=%b (%h,%h,%h) expected v=1 (%h,%h,%h)", k, valid,
                 pc, opcode, operand, 8'(exp_pc), model_store[exp_pc][15:8], model_store[exp_pc][7:0]);
      end
      exp_pc = (exp_pc + 1) % model_len;
      @(negedge clk);
    end
  endtask

  task automatic test_pause();
    int t;
    t = 0;
    while (!(valid && pc == 8'd1) && t < 10) begin
      @(negedge clk);
      t++;
    end
    run_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0 || pc !== 8'd1 || opcode !== 8'h02 || operand !== 8'h33) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: got v=%b (%h,%h,%h) expected v=0 (01,02,33)", k, valid, pc, opcode, operand);
      end
    end
    run_en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || pc !== 8'(k) || opcode !== model_store[k][15:8] || operand !== model_store[k][7:0]) begin
        n_fail++;
        $display("FAIL pause_resume[%0d]: got v=%b (%h,%h,%h) expected v=1 (%h,%h,%h)", k, valid,
                 pc, opcode, operand, 8'(k), model_store[k][15:8], model_store[k][7:0]);
      end
    end
  endtask

  task automatic test_status_partial();
    logic [31:0] rx;
    logic [7:0] exp_status;
    logic [15:0] q[$];
    int t;
    exp_status = {1'b1, 1'b0, 6'(model_len)};
    spi_bus.cs_n = 1'b0;
    t = 0;
    while (valid && t < 4) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL status_valid_drop: got valid=%b after %0d cycles expected 0", valid, t);
    end
    #40;
    n_checks++;
    if (loading !== 1'b1) begin
      n_fail++;
      $display("FAIL status_loading: got %b expected 1", loading);
    end
    spi_shift(32'h03, 8, rx);
    n_checks++;
    if (rx[7:0] !== exp_status) begin
      n_fail++;
      $display("FAIL status_miso: got %h expected %h", rx[7:0], exp_status);
    end
    spi_shift(32'h11, 8, rx);
    spi_shift($urandom, 9, rx);
    spi_end();
    q = '{16'h0311};
    model_program(q);
    @(negedge clk);
    wait_first_valid("partial");
    n_checks++;
    if (prog_len !== 6'd1) begin
      n_fail++;
      $display("FAIL partial_prog_len: got %0d expected 1", prog_len);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (valid !== 1'b1 || pc !== 8'h00 || opcode !== 8'h03 || operand !== 8'h11) begin
        n_fail++;
        $display("FAIL partial_tuple[%0d]: got v=%b (%h,%h,%h) expected v=1 (00,03,11)", k, valid, pc, opcode, operand);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] q[$];
    logic [7:0] n;
    int exp_pc;
    for (int i = 0; i < 33; i++) begin
      n = 8'(i);
      q.push_back({n, ~n});
    end
    run_en = 1'b1;
    load_program(q, 0);
    @(negedge clk);
    wait_first_valid("overrun");
    n_checks++;
    if (prog_len !== 6'd32) begin
      n_fail++;
      $display("FAIL overrun_prog_len: got %0d expected 32", prog_len);
    end
    n_checks++;
    if ({opcode, operand} !== 16'h20DF) begin
      n_fail++;
      $display("FAIL overrun_store0: got %h expected 20df", {opcode, operand});
    end
    exp_pc = 0;
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (valid !== 1'b1 || pc !== 8'(exp_pc) || {opcode, operand} !== model_store[exp_pc]) begin
        n_fail++;
        $display("FAIL overrun_tuple[%0d]: got v=%b pc=%h word=%h expected v=1 pc=%h word=%h", k, valid,
                 pc, {opcode, operand}, 8'(exp_pc), model_store[exp_pc]);
      end
      exp_pc = (exp_pc + 1) % model_len;
      @(negedge clk);
    end
  endtask

  task automatic test_random_run();
    logic [15:0] q[$];
    int len, next_pc, held_pc;
    logic en;
    for (int iter = 0; iter < 3; iter++) begin
      q = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) q.push_back(16'($urandom));
      run_en = 1'b1;
      load_program(q, $urandom_range(0, 15));
      @(negedge clk);
      wait_first_valid("random");
      n_checks++;
      if (pc !== 8'h00 || {opcode, operand} !== model_store[0] || prog_len !== 6'(model_len)) begin
        n_fail++;
        $display("FAIL random_start[%0d]: got pc=%h word=%h len=%0d expected pc=00 word=%h len=%0d", iter,
                 pc, {opcode, operand}, prog_len, model_store[0], model_len);
      end
      held_pc = 0;
      next_pc = 1 % model_len;
      for (int k = 0; k < 60; k++) begin
        en = ($urandom_range(0, 3) != 0);
        run_en = en;
        @(negedge clk);
        if (en) begin
          held_pc = next_pc;
          next_pc = (next_pc + 1) % model_len;
        end else begin
          next_pc = held_pc;
        end
        n_checks++;
        if (valid !== en || pc !== 8'(held_pc) || {opcode, operand} !== model_store[held_pc]) begin
          n_fail++;
          $display("FAIL random_tuple[%0d.%0d]: got v=%b pc=%h word=%h expected v=%b pc=%h word=%h", iter, k,
                   valid, pc, {opcode, operand}, en, 8'(held_pc), model_store[held_pc]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    run_en = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({pc, opcode, operand, valid, prog_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got pc=%h op=%h opr=%h v=%b len=%0d expected all 0",
               pc, opcode, operand, valid, prog_len);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0 || loading !== 1'b0 || prog_len !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got v=%b ld=%b len=%0d expected v=0 ld=0 len=0", k, valid, loading, prog_len);
      end
    end
  endtask

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.cs_n = 1'b1;
    spi_bus.mosi = 1'b0;
    test_reset();
    test_basic_load();
    test_pause();
    test_status_partial();
    test_overrun();
    test_random_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_program_loader.md
Name: spi_program_loader

Overview:
- Upstream feeder for the CPU execution stage.
- An SPI slave (mode 0, MSB first) receives a program of 16-bit instructions (opcode byte, then operand byte) into a 32-entry instruction store.
- After chip-select is released, a sequencer replays the stored program in a loop, presenting one pc/opcode/operand/valid tuple per enabled cycle to the execution unit.
- Also returns a status byte on MISO so the host can confirm the load.

Parameters:
- ROM_ADDRESS_WIDTH, 5, instruction-store address width (depth = 2^5 = 32).
- INPUT_DATA_WIDTH, 4, nibble width; opcode, operand and pc are each INPUT_DATA_WIDTH*2 = 8 bits.
- SYNC_STAGES, 2, flip-flop stages on sclk, cs_n and mosi.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk; clk must be at least 4x sclk.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out (status byte).
- run_en  in  1  1 = sequencer may advance; 0 = hold.
- pc  out  8  address of the presented instruction, zero-extended from ROM_ADDRESS_WIDTH.
- opcode  out  8  instruction byte 0.
- operand  out  8  instruction byte 1 (bits 7:4 = A, 3:0 = B).
- valid  out  1  tuple is valid this cycle.
- prog_len  out  6  number of complete instructions stored (0..32).
- loading  out  1  high while in LOAD.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; pc, opcode, operand, valid, prog_len, loading = 0; miso = 0; write pointer = 0; bit counter = 0. Store contents are not reset.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. sclk rise/fall and cs_n fall/rise are detected on the synchronised signals.
- States: IDLE, LOAD, RUN.
- Any state, cs_n fall:
  - enter LOAD next cycle; loading = 1;
  - valid = 0 from that cycle on; pc = 0;
  - write pointer and bit counter cleared;
  - miso shift register loaded with status byte {state_was_run, 1'b0, prog_len[5:0]}.
- LOAD, receive: on each sclk rise, shift mosi into a 16-bit register (MSB first) and increment the bit counter. When bit 16 arrives:
  - write the word into store[wptr];
  - wptr increments and wraps 31 -> 0;
  - stored count saturates at 32;
  - bit counter clears.
- LOAD, transmit: on each sclk fall, miso shifts the next status bit, MSB first. After 8 bits miso holds 0.
- cs_n rise:
  - a partial word (bit counter != 0) is discarded;
  - prog_len = stored count, registered;
  - loading = 0;
  - go to RUN if count > 0, else IDLE.
- RUN:
  - Store read is registered (1-cycle latency).
  - The first tuple (pc = 0) appears with valid = 1 two cycles after the cs_n rise is detected, provided run_en = 1.
  - Each cycle with run_en = 1: present store[pc] with valid = 1, then pc <= (pc == prog_len-1) ? 0 : pc+1.
  - run_en = 0: valid = 0 and pc, opcode, operand hold. On resume, the held pc is re-presented first (no instruction skipped or duplicated).
- prog_len = 1: the same instruction is presented every enabled cycle with pc = 0.
- Simultaneous events: if a cs_n fall and a run_en change land in the same cycle, the cs_n fall wins.
- Reset mid-load: the partially loaded store is retained, but prog_len = 0, so the block stays in IDLE until the next complete load.
- Overrun: more than 32 words wraps and overwrites from entry 0; prog_len = 32.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/RUN), status-byte field positions, INSTR_WIDTH = 16.
- One natural sub-module, spi_slave_rx: synchronisers, edge detect, 16-bit shift-in, status shift-out, word_valid strobe.
- The store and sequencer stay in the top module.

Test Plan:
- Reset: assert reset = 0 mid-RUN -> pc, opcode, operand, valid, prog_len all 0 asynchronously; state IDLE after release.
- Load 3 words 0x01A5, 0x0233, 0x0400, then raise cs_n with run_en = 1 -> prog_len = 3. Tuples (pc, opcode, operand) appear as (0,01,A5), (1,02,33), (2,04,00), then (0,01,A5) repeating, with valid continuously 1.
- Mid-run pause: run_en low at pc = 1 for 5 cycles -> valid = 0 and outputs hold 1/02/33. On resume the next valid tuple is pc = 1, then pc = 2.
- Partial word: send 0x0311 plus 9 extra bits, then release cs_n -> prog_len = 1; only (0,03,11) repeats.
- Status/miso: after the first load of 3 words in RUN, start a new transfer -> first 8 miso bits = 0x83. valid drops to 0 within SYNC_STAGES+2 cycles of the cs_n fall.
- Overrun: load 33 words with word n = {n[7:0], ~n[7:0]} -> prog_len = 32; store[0] = 0x20DF; pc sequence wraps 31 -> 0.
